// File: rtl/rot_share_arbiter_if.sv
// Request/result bundle for rot_share_arbiter.
//   req_valid/req_ready : per-requester handshake (bit i = requester i)
//   reqX_data/amt/dir_lr: requester operands (dir_lr 1 = rotate left)
//   out_valid/out_ready : result-slot handshake
//   out_data/out_tag    : rotated word and index of the requester that produced it
// Modport slave is the arbiter side; master is the client/consumer side.
interface rot_share_arbiter_if #(
  parameter int unsigned N = 8
);
  localparam int unsigned WIDTH = 2 ** N;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req0_data;
  logic [N-1:0]     req0_amt;
  logic             req0_dir_lr;
  logic [WIDTH-1:0] req1_data;
  logic [N-1:0]     req1_amt;
  logic             req1_dir_lr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_tag;

  modport slave (
    input  req_valid, req0_data, req0_amt, req0_dir_lr,
    input  req1_data, req1_amt, req1_dir_lr, out_ready,
    output req_ready, out_valid, out_data, out_tag
  );

  modport master (
    output req_valid, req0_data, req0_amt, req0_dir_lr,
    output req1_data, req1_amt, req1_dir_lr, out_ready,
    input  req_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/rot_share_arbiter.sv
// Two-requester round-robin front end for one shared rotator.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : rot_share_arbiter_if.slave (request channels + single-slot result channel)
// A request is accepted only when the result slot is free (empty, or draining this
// cycle); the winning operand is rotated combinationally and registered into the slot.
module rot_share_arbiter #(
  parameter int unsigned N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  rot_share_arbiter_if.slave    bus
);
  localparam int unsigned WIDTH = 2 ** N;

  // Log-depth left rotator; stage s rotates by 2**s when amt[s] is set.
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d,
                                            input logic [N-1:0] amt);
    logic [WIDTH-1:0] x;
    x = d;
    for (int s = 0; s < int'(N); s++) begin
      if (amt[s]) begin
        x = (x << (1 << s)) | (x >> (int'(WIDTH) - (1 << s)));
      end
    end
    return x;
  endfunction

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_tag;
  logic             r_last_grant;

  logic             w_slot_free;
  logic             w_grant_valid;
  logic             w_grant_idx;
  logic [1:0]       w_req_ready;
  logic [WIDTH-1:0] w_sel_data;
  logic [N-1:0]     w_sel_amt;
  logic             w_sel_dir_lr;
  logic [N-1:0]     w_left_amt;
  logic [WIDTH-1:0] w_rot_data;

  // Slot can take a new result if empty or being drained in this same cycle.
  assign w_slot_free = !r_out_valid || bus.out_ready;

  // Grant depends only on valids and last_grant, never on operand data.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = 1'b0;
    unique case (bus.req_valid)
      2'b01: begin
        w_grant_valid = 1'b1;
        w_grant_idx   = 1'b0;
      end
      2'b10: begin
        w_grant_valid = 1'b1;
        w_grant_idx   = 1'b1;
      end
      2'b11: begin
        w_grant_valid = 1'b1;
        w_grant_idx   = ~r_last_grant;
      end
      default: begin
        w_grant_valid = 1'b0;
        w_grant_idx   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_req_ready = 2'b00;
    if (w_slot_free && w_grant_valid) begin
      w_req_ready = w_grant_idx ? 2'b10 : 2'b01;
    end
  end

  assign w_sel_data   = w_grant_idx ? bus.req1_data   : bus.req0_data;
  assign w_sel_amt    = w_grant_idx ? bus.req1_amt    : bus.req0_amt;
  assign w_sel_dir_lr = w_grant_idx ? bus.req1_dir_lr : bus.req0_dir_lr;

  // Right rotate by a equals left rotate by (WIDTH - a) mod WIDTH, i.e. -a in N bits.
  assign w_left_amt = w_sel_dir_lr ? w_sel_amt : (~w_sel_amt + 1'b1);
  assign w_rot_data = rotl(w_sel_data, w_left_amt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_tag    <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_slot_free) begin
      r_out_valid <= w_grant_valid;
      if (w_grant_valid) begin
        r_out_data   <= w_rot_data;
        r_out_tag    <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_tag   = r_out_tag;
endmodule
